// File: rtl/sdr_init_pkg.sv
// SDRAM power-up initialization: shared command encodings, sequencer state type and
// a small helper for sizing the wait counter.
package sdr_init_pkg;

  // Command encodings as {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  typedef enum logic [3:0] {
    StReset,
    StInitWait,
    StPrecharge,
    StTrpWait,
    StRefresh,
    StTrfcWait,
    StLoadMode,
    StTmrdWait,
    StDone
  } init_state_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sdr_init_timer.sv
// Loadable down-counter used for every NOP wait of the init sequencer.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - load load_val this edge (wins over counting)
//   load_val  - number of cycles to wait
//   expire    - high during the last cycle of the loaded wait (one cycle only)
module sdr_init_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  // Counts down to zero and parks there, so expire pulses exactly once per load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/sdr_init_seq.sv
// SDRAM power-up initialization sequencer. After reset release it drives NOP for
// T_INIT_WAIT cycles, then PRECHARGE-ALL, N_REFRESH x AUTO REFRESH and LOAD MODE
// REGISTER with their NOP gaps, then raises init_done. init_req in DONE re-runs the
// sequence from PRECHARGE.
// Ports:
//   sdram_clk, sdram_rst - clock and synchronous active-high reset
//   cfg_mode_reg         - mode register value, captured during the PRECHARGE cycle
//   init_req             - re-initialize request, only honoured in DONE
//   sdr_*                - registered SDRAM command/address pins
//   init_busy/init_done  - sequence status
module sdr_init_seq
  import sdr_init_pkg::*;
#(
  parameter int unsigned T_INIT_WAIT = 500,
  parameter int unsigned T_RP        = 2,
  parameter int unsigned T_RFC       = 7,
  parameter int unsigned N_REFRESH   = 2,
  parameter int unsigned T_MRD       = 2,
  parameter int unsigned ADDR_W      = 13
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst,
  input  logic [ADDR_W-1:0] cfg_mode_reg,
  input  logic              init_req,
  output logic              sdr_cke,
  output logic              sdr_cs_n,
  output logic              sdr_ras_n,
  output logic              sdr_cas_n,
  output logic              sdr_we_n,
  output logic [1:0]        sdr_ba,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic              init_busy,
  output logic              init_done
);

  localparam int unsigned TMax = max4(T_INIT_WAIT, T_RP, T_RFC, T_MRD);
  localparam int unsigned TW   = $clog2(TMax) + 1;
  localparam int unsigned RW   = $clog2(N_REFRESH + 1);

  init_state_t       state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              cke_q, cke_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mode_q;
  logic [RW-1:0]     ref_cnt_q;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_expire;

  sdr_init_timer #(
    .W(TW)
  ) u_timer (
    .clk     (sdram_clk),
    .rst     (sdram_rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expire  (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = CMD_NOP;
    cke_d    = 1'b1;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    addr_d   = '0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      StReset:     state_d = StInitWait;
      StInitWait:  if (tmr_expire) state_d = StPrecharge;
      StPrecharge: state_d = StTrpWait;
      StTrpWait:   if (tmr_expire) state_d = StRefresh;
      StRefresh:   state_d = StTrfcWait;
      StTrfcWait: begin
        if (tmr_expire) begin
          state_d = (ref_cnt_q < RW'(N_REFRESH)) ? StRefresh : StLoadMode;
        end
      end
      StLoadMode:  state_d = StTmrdWait;
      StTmrdWait:  if (tmr_expire) state_d = StDone;
      StDone:      if (init_req) state_d = StPrecharge;
      default:     state_d = StReset;
    endcase

    // Outputs are decoded from the next state so they appear registered with it.
    case (state_d)
      StReset: begin
        cmd_d  = CMD_DESEL;
        cke_d  = 1'b0;
        busy_d = 1'b0;
      end
      StPrecharge: begin
        cmd_d      = CMD_PRE;
        addr_d[10] = 1'b1;
      end
      StRefresh:  cmd_d = CMD_REF;
      StLoadMode: begin
        cmd_d  = CMD_LMR;
        addr_d = mode_q;
      end
      StDone: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase

    // Each wait state loads its timer on entry.
    if (state_d != state_q) begin
      case (state_d)
        StInitWait: begin tmr_load = 1'b1; tmr_val = TW'(T_INIT_WAIT); end
        StTrpWait:  begin tmr_load = 1'b1; tmr_val = TW'(T_RP);        end
        StTrfcWait: begin tmr_load = 1'b1; tmr_val = TW'(T_RFC);       end
        StTmrdWait: begin tmr_load = 1'b1; tmr_val = TW'(T_MRD);       end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q   <= StReset;
      cmd_q     <= CMD_DESEL;
      cke_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      mode_q    <= '0;
      ref_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cke_q   <= cke_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      if (state_q == StPrecharge) mode_q <= cfg_mode_reg;
      if (state_d == StPrecharge && state_q != StPrecharge) begin
        ref_cnt_q <= '0;
      end else if (state_q == StRefresh) begin
        ref_cnt_q <= ref_cnt_q + RW'(1);
      end
    end
  end

  assign sdr_cke   = cke_q;
  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
  assign sdr_ba    = 2'b00;
  assign sdr_addr  = addr_q;
  assign init_busy = busy_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_sdr_init_seq.sv
// Bench for sdr_init_seq: one instance with default timing, one with minimal timing.
// Expected pin traces are built as command lists from the timing parameters.
module tb_sdr_init_seq;

  localparam int AW = 13;
  localparam logic [3:0] C_DES = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  typedef logic [21:0] snap_t;  // {cke, cmd, ba, addr, busy, done}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, req_a, rst_b, req_b;
  logic [AW-1:0] mode_a, mode_b;
  logic          cke_a, cs_a, ras_a, cas_a, we_a, busy_a, done_a;
  logic          cke_b, cs_b, ras_b, cas_b, we_b, busy_b, done_b;
  logic [1:0]    ba_a, ba_b;
  logic [AW-1:0] addr_a, addr_b;

  sdr_init_seq u_dut_a (
    .sdram_clk(clk), .sdram_rst(rst_a), .cfg_mode_reg(mode_a), .init_req(req_a),
    .sdr_cke(cke_a), .sdr_cs_n(cs_a), .sdr_ras_n(ras_a), .sdr_cas_n(cas_a),
    .sdr_we_n(we_a), .sdr_ba(ba_a), .sdr_addr(addr_a), .init_busy(busy_a),
    .init_done(done_a)
  );

  sdr_init_seq #(
    .T_INIT_WAIT(4), .T_RP(1), .T_RFC(1), .N_REFRESH(1), .T_MRD(1), .ADDR_W(13)
  ) u_dut_b (
    .sdram_clk(clk), .sdram_rst(rst_b), .cfg_mode_reg(mode_b), .init_req(req_b),
    .sdr_cke(cke_b), .sdr_cs_n(cs_b), .sdr_ras_n(ras_b), .sdr_cas_n(cas_b),
    .sdr_we_n(we_b), .sdr_ba(ba_b), .sdr_addr(addr_b), .init_busy(busy_b),
    .init_done(done_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  snap_t exp_q[$];

  function automatic snap_t pk(logic cke, logic [3:0] cmd, logic [AW-1:0] addr, logic busy,
                               logic done);
    return {cke, cmd, 2'b00, addr, busy, done};
  endfunction

  function automatic snap_t obs(int which);
    if (which == 0) return {cke_a, cs_a, ras_a, cas_a, we_a, ba_a, addr_a, busy_a, done_a};
    return {cke_b, cs_b, ras_b, cas_b, we_b, ba_b, addr_b, busy_b, done_b};
  endfunction

  task automatic check(string tag, snap_t o, snap_t e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic set_rst(int which, logic v);
    if (which == 0) rst_a = v; else rst_b = v;
  endtask
  task automatic set_req(int which, logic v);
    if (which == 0) req_a = v; else req_b = v;
  endtask
  task automatic set_mode(int which, logic [AW-1:0] v);
    if (which == 0) mode_a = v; else mode_b = v;
  endtask

  // Reference: the ordered list of pin states the device must see, one per cycle.
  task automatic build(int which, bit full, logic [AW-1:0] m);
    int tw, trp, trfc, nref, tmrd;
    snap_t nop;
    tw   = (which == 0) ? 500 : 4;
    trp  = (which == 0) ? 2 : 1;
    trfc = (which == 0) ? 7 : 1;
    nref = (which == 0) ? 2 : 1;
    tmrd = (which == 0) ? 2 : 1;
    nop  = pk(1'b1, C_NOP, '0, 1'b1, 1'b0);
    exp_q = {};
    if (full) repeat (tw) exp_q.push_back(nop);
    exp_q.push_back(pk(1'b1, C_PRE, 13'h0400, 1'b1, 1'b0));
    repeat (trp) exp_q.push_back(nop);
    repeat (nref) begin
      exp_q.push_back(pk(1'b1, C_REF, '0, 1'b1, 1'b0));
      repeat (trfc) exp_q.push_back(nop);
    end
    exp_q.push_back(pk(1'b1, C_LMR, m, 1'b1, 1'b0));
    repeat (tmrd) exp_q.push_back(nop);
  endtask

  // Walks the expected trace; mode input is changed one cycle after PRE to prove capture.
  task automatic run_seq(int which, bit full, logic [AW-1:0] m, logic [AW-1:0] later_m,
                         bit noise, int abort_at, string name);
    int pre_idx;
    pre_idx = full ? ((which == 0) ? 500 : 4) : 0;
    build(which, full, m);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      check($sformatf("%s[%0d]", name, i), obs(which), exp_q[i]);
      if (i == pre_idx + 1) set_mode(which, later_m);
      set_req(which, noise ? logic'($urandom_range(0, 1)) : 1'b0);
      if (i == abort_at) begin
        set_rst(which, 1'b1);
        set_req(which, 1'b0);
        @(posedge clk); #1;
        check({name, "_rst"}, obs(which), pk(1'b0, C_DES, '0, 1'b0, 1'b0));
        set_rst(which, 1'b0);
        return;
      end
    end
    @(posedge clk); #1;
    check({name, "_done"}, obs(which), pk(1'b1, C_NOP, '0, 1'b0, 1'b1));
    set_req(which, 1'b0);
  endtask

  task automatic idle_done(int which, string name);
    repeat ($urandom_range(1, 4)) begin
      @(posedge clk); #1;
      check(name, obs(which), pk(1'b1, C_NOP, '0, 1'b0, 1'b1));
    end
  endtask

  initial begin
    logic [AW-1:0] m;
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
    mode_a = 13'h0033; mode_b = '0;

    repeat (5) @(posedge clk);
    #1;
    check("a_reset", obs(0), pk(1'b0, C_DES, '0, 1'b0, 1'b0));
    check("b_reset", obs(1), pk(1'b0, C_DES, '0, 1'b0, 1'b0));

    // Power-up with mode 0033, changed to 1FFF after PRE.
    rst_a = 1'b0;
    run_seq(0, 1'b1, 13'h0033, 13'h1FFF, 1'b0, -1, "a_pwrup");
    idle_done(0, "a_idle0");

    // Re-init from DONE: no power-up wait.
    m = AW'($urandom);
    mode_a = m;
    req_a = 1'b1;
    run_seq(0, 1'b0, m, ~m, 1'b0, -1, "a_reinit");
    idle_done(0, "a_idle1");

    // Full restart with init_req toggling randomly throughout; it must be ignored.
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("a_rst2", obs(0), pk(1'b0, C_DES, '0, 1'b0, 1'b0));
    rst_a = 1'b0;
    m = AW'($urandom);
    mode_a = m;
    run_seq(0, 1'b1, m, ~m, 1'b1, -1, "a_noise");
    idle_done(0, "a_idle2");

    // One-cycle reset inside the first tRFC wait, then the whole sequence again.
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    m = AW'($urandom);
    mode_a = m;
    run_seq(0, 1'b1, m, ~m, 1'b0, 504 + int'($urandom_range(0, 6)), "a_abort");
    m = AW'($urandom);
    mode_a = m;
    run_seq(0, 1'b1, m, ~m, 1'b0, -1, "a_restart");

    // Minimal-timing instance.
    m = AW'($urandom);
    mode_b = m;
    rst_b = 1'b0;
    run_seq(1, 1'b1, m, ~m, 1'b0, -1, "b_small");
    idle_done(1, "b_idle");
    m = AW'($urandom);
    mode_b = m;
    req_b = 1'b1;
    run_seq(1, 1'b0, m, ~m, 1'b1, -1, "b_reinit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
